// File: rtl/secure_mem_pkg.sv
// Shared constants for the secure keystore: default geometry, the key table
// loaded at reset, the read-protection mask and the sequencer state type.
package secure_mem_pkg;

  localparam int unsigned KS_WIDTH = 256;
  localparam int unsigned KS_DEPTH = 16;
  localparam int unsigned KS_AW    = $clog2(KS_DEPTH);

  // Slot 2 = comm key, 6 = signing key, 10..13 = device keys.
  localparam logic [KS_WIDTH-1:0] KEY_INIT [KS_DEPTH] = '{
    2:  256'h4936_a1c7_0b5e_92d4_6f83_c21a_57e9_0d4b_b3f6_18a2_7c5d_e094_21b8_6a3f_d7c0_ef1b,
    6:  256'h9e41_7b2c_d05a_33f8_61c9_a4e7_0f12_b85d_2a6e_c3f1_947b_05d8_e62a_1fc4_8b39_70ad,
    10: 256'h4319_f0a6_2d8e_b57c_19e3_6a04_c2df_8b71_5e2a_93c6_07fd_4b18_a6e9_3c52_d184_7c0b,
    11: 256'h2c7e_95a1_f3b8_046d_ae52_17c9_6d0f_b2e4_83a7_5c1e_f96b_2d40_7ae3_c815_04bf_96d2,
    12: 256'hd58a_1e3f_7c62_b094_4fa1_e8d7_3b25_960c_c1e4_5a7f_0d39_b86e_24f1_9ac7_635e_08b1,
    13: 256'h6b0d_c492_8e17_f35a_a26c_4d81_09fe_b7c3_5d28_e64a_713b_cf90_3e85_a1d6_f24c_b97e,
    default: '0
  };

  localparam logic [KS_DEPTH-1:0] SECRET_MASK = 16'h0040;

  typedef enum logic {IDLE, ZERO} ks_state_e;

  // Entries beyond the table (larger DEPTH builds) start as zero and are public.
  function automatic logic [KS_WIDTH-1:0] key_init_at(input int unsigned idx);
    return (idx < KS_DEPTH) ? KEY_INIT[idx[KS_AW-1:0]] : '0;
  endfunction

  function automatic logic is_secret(input int unsigned idx);
    return (idx < KS_DEPTH) ? SECRET_MASK[idx[KS_AW-1:0]] : 1'b0;
  endfunction

endpackage

// File: rtl/secure_keystore_if.sv
// Request/response port of the secure keystore.
interface secure_keystore_if #(
  parameter int unsigned WIDTH = 256,
  parameter int unsigned AW    = 4
);
  logic             req_valid;
  logic             req_ready;
  logic             req_we;
  logic [AW-1:0]    req_addr;
  logic [WIDTH-1:0] req_wdata;
  logic             rsp_valid;
  logic [WIDTH-1:0] rsp_rdata;
  logic             rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/secure_keystore.sv
// Key store with sticky per-entry write locks, read-protected slots and a
// one-entry-per-cycle zeroize sequencer.
module secure_keystore
  import secure_mem_pkg::*;
#(
  parameter  int unsigned WIDTH = KS_WIDTH,
  parameter  int unsigned DEPTH = KS_DEPTH,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  secure_keystore_if.slave      bus,
  input  logic                  lock_en,
  input  logic [AW-1:0]         lock_addr,
  input  logic                  zeroize,
  output logic                  busy
);

  // Range checks are one bit wider so a non-power-of-two DEPTH compares safely.
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);

  ks_state_e        state_q, state_d;
  logic [AW-1:0]    zcnt_q, zcnt_d;
  logic [DEPTH-1:0] lock_q, lock_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             busy_q, busy_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

  logic req_ready, accept, req_in_range, lock_in_range, lock_set, lock_hit;

  assign req_ready     = (state_q == IDLE) & ~zeroize;
  assign accept        = bus.req_valid & req_ready;
  assign req_in_range  = {1'b0, bus.req_addr} < DEPTH_W;
  assign lock_in_range = {1'b0, lock_addr} < DEPTH_W;
  assign lock_set      = (state_q == IDLE) & lock_en & lock_in_range;
  // A lock landing in the same cycle as a write to that entry beats the write.
  assign lock_hit      = lock_set & (lock_addr == bus.req_addr);

  always_comb begin
    mem_d       = mem_q;
    lock_d      = lock_q;
    state_d     = state_q;
    zcnt_d      = zcnt_q;
    busy_d      = busy_q;
    rsp_valid_d = accept;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;

    if (accept) begin
      if (!req_in_range) begin
        rsp_err_d = 1'b1;
      end else if (bus.req_we) begin
        if (lock_q[bus.req_addr] | lock_hit) rsp_err_d = 1'b1;
        else mem_d[bus.req_addr] = bus.req_wdata;
      end else if (is_secret(32'(bus.req_addr))) begin
        rsp_err_d = 1'b1;
      end else begin
        rsp_rdata_d = mem_q[bus.req_addr];
      end
    end

    case (state_q)
      IDLE: begin
        if (lock_set) lock_d[lock_addr] = 1'b1;
        if (zeroize) begin
          state_d = ZERO;
          zcnt_d  = '0;
          busy_d  = 1'b1;
        end
      end
      ZERO: begin
        mem_d[zcnt_q] = '0;
        if ({1'b0, zcnt_q} == LAST_W) begin
          lock_d  = '0;
          state_d = IDLE;
          zcnt_d  = '0;
          busy_d  = 1'b0;
        end else begin
          zcnt_d = zcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i[AW-1:0]] <= WIDTH'(key_init_at(i));
      lock_q      <= '0;
      state_q     <= IDLE;
      zcnt_q      <= '0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      mem_q       <= mem_d;
      lock_q      <= lock_d;
      state_q     <= state_d;
      zcnt_q      <= zcnt_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_secure_keystore.sv
// Bench for secure_keystore: directed and random traffic against a behavioural
// model, plus a DEPTH=17 instance for out-of-range addressing.
module tb_secure_keystore;

  localparam logic [255:0] K2  = 256'h4936_a1c7_0b5e_92d4_6f83_c21a_57e9_0d4b_b3f6_18a2_7c5d_e094_21b8_6a3f_d7c0_ef1b;
  localparam logic [255:0] K6  = 256'h9e41_7b2c_d05a_33f8_61c9_a4e7_0f12_b85d_2a6e_c3f1_947b_05d8_e62a_1fc4_8b39_70ad;
  localparam logic [255:0] K10 = 256'h4319_f0a6_2d8e_b57c_19e3_6a04_c2df_8b71_5e2a_93c6_07fd_4b18_a6e9_3c52_d184_7c0b;
  localparam logic [255:0] K11 = 256'h2c7e_95a1_f3b8_046d_ae52_17c9_6d0f_b2e4_83a7_5c1e_f96b_2d40_7ae3_c815_04bf_96d2;
  localparam logic [255:0] K12 = 256'hd58a_1e3f_7c62_b094_4fa1_e8d7_3b25_960c_c1e4_5a7f_0d39_b86e_24f1_9ac7_635e_08b1;
  localparam logic [255:0] K13 = 256'h6b0d_c492_8e17_f35a_a26c_4d81_09fe_b7c3_5d28_e64a_713b_cf90_3e85_a1d6_f24c_b97e;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  secure_keystore_if #(.WIDTH(256), .AW(4)) bus16 ();
  logic       lock_en, zeroize, busy;
  logic [3:0] lock_addr;

  secure_keystore #(.WIDTH(256), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .bus(bus16.slave),
    .lock_en(lock_en), .lock_addr(lock_addr), .zeroize(zeroize), .busy(busy)
  );

  secure_keystore_if #(.WIDTH(256), .AW(5)) bus17 ();
  logic       lock_en17, zeroize17, busy17;
  logic [4:0] lock_addr17;

  secure_keystore #(.WIDTH(256), .DEPTH(17)) dut17 (
    .clk(clk), .rst(rst), .bus(bus17.slave),
    .lock_en(lock_en17), .lock_addr(lock_addr17), .zeroize(zeroize17), .busy(busy17)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [255:0] m_mem  [16];
  bit           m_lock [16];
  int           m_zleft;

  task automatic check_val(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [255:0] tb_key(input int i);
    case (i)
      2: return K2;    6: return K6;
      10: return K10;  11: return K11;
      12: return K12;  13: return K13;
      default: return '0;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_mem[i[3:0]]  = tb_key(i);
      m_lock[i[3:0]] = 1'b0;
    end
    m_zleft = 0;
  endtask

  // One cycle on the DEPTH=16 instance; the model decides acceptance and response.
  task automatic step(input bit v, input bit we, input bit [3:0] addr, input logic [255:0] wd,
                      input bit le, input bit [3:0] la, input bit z);
    bit acc, exp_ready, exp_err;
    logic [255:0] exp_rd;
    bus16.req_valid = v;  bus16.req_we = we;  bus16.req_addr = addr;  bus16.req_wdata = wd;
    lock_en = le;  lock_addr = la;  zeroize = z;
    #1;
    exp_ready = (m_zleft == 0) && !z;
    check_val("req_ready", 256'(bus16.req_ready), 256'(exp_ready));
    acc = v && exp_ready;
    exp_err = 1'b0;
    exp_rd = '0;
    if (acc) begin
      if (we) begin
        if (m_lock[addr] || (le && la == addr)) exp_err = 1'b1;
        else m_mem[addr] = wd;
      end else if (addr == 4'd6) exp_err = 1'b1;
      else exp_rd = m_mem[addr];
    end
    if (m_zleft > 0) begin
      m_zleft--;
      if (m_zleft == 0)
        for (int i = 0; i < 16; i++) begin
          m_mem[i[3:0]]  = '0;
          m_lock[i[3:0]] = 1'b0;
        end
    end else begin
      if (le) m_lock[la] = 1'b1;
      if (z) m_zleft = 16;
    end
    @(posedge clk);
    #1;
    check_val("rsp_valid", 256'(bus16.rsp_valid), 256'(acc));
    if (acc) begin
      check_val("rsp_err", 256'(bus16.rsp_err), 256'(exp_err));
      check_val("rsp_rdata", bus16.rsp_rdata, exp_rd);
    end
    check_val("busy", 256'(busy), 256'(m_zleft > 0));
  endtask

  task automatic step17(input bit v, input bit we, input bit [4:0] addr, input logic [255:0] wd,
                        input bit le, input bit [4:0] la, input bit exp_err, input logic [255:0] exp_rd);
    bus17.req_valid = v;  bus17.req_we = we;  bus17.req_addr = addr;  bus17.req_wdata = wd;
    lock_en17 = le;  lock_addr17 = la;  zeroize17 = 1'b0;
    #1;
    check_val("d17_ready", 256'(bus17.req_ready), 256'(1'b1));
    @(posedge clk);
    #1;
    check_val("d17_valid", 256'(bus17.rsp_valid), 256'(v));
    if (v) begin
      check_val("d17_err", 256'(bus17.rsp_err), 256'(exp_err));
      check_val("d17_rdata", bus17.rsp_rdata, exp_rd);
    end
  endtask

  initial begin
    logic [255:0] a5, pat, wd;
    int cnt;

    a5  = {32{8'hA5}};
    pat = 256'h0123_4567_89ab_cdef_0011_2233_4455_6677_8899_aabb_ccdd_eeff_f0e1_d2c3_b4a5_9687;
    rst = 1'b1;
    bus16.req_valid = 1'b0;  bus16.req_we = 1'b0;  bus16.req_addr = '0;  bus16.req_wdata = '0;
    lock_en = 1'b0;  lock_addr = '0;  zeroize = 1'b0;
    bus17.req_valid = 1'b0;  bus17.req_we = 1'b0;  bus17.req_addr = '0;  bus17.req_wdata = '0;
    lock_en17 = 1'b0;  lock_addr17 = '0;  zeroize17 = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check_val("rst_busy", 256'(busy), '0);
    check_val("rst_rsp_valid", 256'(bus16.rsp_valid), '0);
    check_val("rst_rsp_err", 256'(bus16.rsp_err), '0);
    check_val("rst_rsp_rdata", bus16.rsp_rdata, '0);
    check_val("rst_req_ready", 256'(bus16.req_ready), 256'(1'b1));

    // Reads: public key, secret slot
    step(1, 0, 4'd2, '0, 0, 4'd0, 0);
    check_val("key2_lit", bus16.rsp_rdata, K2);
    step(1, 0, 4'd6, '0, 0, 4'd0, 0);
    // Back-to-back write/read, then an idle cycle
    step(1, 1, 4'd3, a5, 0, 4'd0, 0);
    step(1, 0, 4'd3, '0, 0, 4'd0, 0);
    check_val("addr3_a5", bus16.rsp_rdata, a5);
    step(0, 0, 4'd0, '0, 0, 4'd0, 0);
    // Lock collides with write to the same entry
    step(1, 1, 4'd3, 256'h1, 1, 4'd3, 0);
    check_val("lock_wins_err", 256'(bus16.rsp_err), 256'(1'b1));
    step(1, 0, 4'd3, '0, 0, 4'd0, 0);
    step(0, 0, 4'd0, '0, 1, 4'd4, 0);
    step(1, 1, 4'd5, pat, 0, 4'd0, 0);
    step(1, 1, 4'd4, pat, 0, 4'd0, 0);
    step(1, 0, 4'd5, '0, 0, 4'd0, 0);

    // Zeroize with requests pending every cycle and repeated zeroize mid-sequence
    cnt = 0;
    step(1, 0, 4'd2, '0, 0, 4'd0, 1);
    if (busy) cnt++;
    for (int i = 0; i < 19; i++) begin
      step(1, 0, 4'd2, '0, (i == 3), 4'd7, (m_zleft > 1) && i[0]);
      if (busy) cnt++;
    end
    check_val("zero_busy_cycles", 256'(cnt), 256'(16));
    step(1, 0, 4'd2, '0, 0, 4'd0, 0);
    step(1, 0, 4'd10, '0, 0, 4'd0, 0);
    step(1, 0, 4'd3, '0, 0, 4'd0, 0);
    step(1, 1, 4'd3, pat, 0, 4'd0, 0);
    step(1, 0, 4'd3, '0, 0, 4'd0, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 8; k++) wd[k*32 +: 32] = $urandom;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), wd,
           $urandom_range(0, 31) == 0, 4'($urandom_range(0, 15)), $urandom_range(0, 63) == 0);
    end

    // Reset in the middle of a zeroize
    for (int i = 0; i < 20 && m_zleft > 0; i++) step(0, 0, 4'd0, '0, 0, 4'd0, 0);
    check_val("pre_z_idle", 256'(busy), '0);
    step(0, 0, 4'd0, '0, 0, 4'd0, 1);
    repeat (5) step(0, 0, 4'd0, '0, 0, 4'd0, 0);
    #2 rst = 1'b1;
    #1;
    check_val("midz_rst_busy", 256'(busy), '0);
    check_val("midz_rst_valid", 256'(bus16.rsp_valid), '0);
    model_reset();
    #3 rst = 1'b0;
    step(1, 0, 4'd2, '0, 0, 4'd0, 0);
    check_val("reload_key2", bus16.rsp_rdata, K2);
    step(1, 0, 4'd10, '0, 0, 4'd0, 0);
    check_val("reload_key10", bus16.rsp_rdata, K10);

    // DEPTH=17 instance: address 16 is real, 17..31 are out of range
    step17(1, 0, 5'd17, '0, 0, 5'd0, 1, '0);
    step17(1, 1, 5'd31, pat, 0, 5'd0, 1, '0);
    step17(1, 0, 5'd31, '0, 0, 5'd0, 1, '0);
    step17(1, 0, 5'd6, '0, 0, 5'd0, 1, '0);
    step17(1, 0, 5'd16, '0, 0, 5'd0, 0, '0);
    step17(1, 1, 5'd16, pat, 1, 5'd20, 0, '0);
    step17(1, 0, 5'd16, '0, 0, 5'd0, 0, pat);
    step17(1, 0, 5'd2, '0, 0, 5'd0, 0, K2);
    step17(1, 1, 5'd16, a5, 1, 5'd16, 1, '0);
    step17(1, 0, 5'd16, '0, 0, 5'd0, 0, pat);
    zeroize17 = 1'b1;
    @(posedge clk);
    #1 zeroize17 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 40 && busy17; i++) begin
      cnt++;
      check_val("d17_ready_busy", 256'(bus17.req_ready), '0);
      @(posedge clk);
      #1;
    end
    check_val("d17_busy_cycles", 256'(cnt), 256'(17));
    step17(1, 0, 5'd16, '0, 0, 5'd0, 0, '0);
    step17(1, 1, 5'd16, a5, 0, 5'd0, 0, '0);
    step17(1, 0, 5'd16, '0, 0, 5'd0, 0, a5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
